// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter_if
// Brief   : FIFO / transmitter / control bundle between arbiter and its peers.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
    logic        enable;
    logic        prio_mode;
    logic        f0_empty;
    logic        f1_empty;
    logic [7:0]  f0_data;
    logic [7:0]  f1_data;
    logic        f0_rd_en;
    logic        f1_rd_en;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant;
    logic [15:0] frames_sent;
    logic        clr_err;
    logic        err_timeout;

    modport master (
        input  enable, prio_mode, f0_empty, f1_empty, f0_data, f1_data,
               tx_busy, clr_err,
        output f0_rd_en, f1_rd_en, tx_start, tx_data, grant, frames_sent,
               err_timeout
    );

    modport slave (
        output enable, prio_mode, f0_empty, f1_empty, f0_data, f1_data,
               tx_busy, clr_err,
        input  f0_rd_en, f1_rd_en, tx_start, tx_data, grant, frames_sent,
               err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Two-source FIFO-to-UART arbiter, round-robin or fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int ACK_TIMEOUT = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    uart_tx_arbiter_if.master     bus
);

    localparam int c_CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_LATCH     = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_DONE = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_f0_rd_en;
    logic               r_f1_rd_en;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [1:0]         r_grant;
    logic [15:0]        r_frames_sent;
    logic               r_err;
    logic               r_last_src;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_f0_ready;
    logic w_f1_ready;
    logic w_any;
    logic w_pick1;

    assign w_f0_ready = !bus.f0_empty;
    assign w_f1_ready = !bus.f1_empty;
    assign w_any      = w_f0_ready || w_f1_ready;
    // Source 1 wins when alone, or in round-robin when source 0 went last.
    assign w_pick1    = w_f1_ready &&
                        (!w_f0_ready || (!bus.prio_mode && !r_last_src));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_f0_rd_en    <= 1'b0;
            r_f1_rd_en    <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_grant       <= 2'b00;
            r_frames_sent <= 16'h0000;
            r_err         <= 1'b0;
            r_last_src    <= 1'b1;
            r_cnt         <= '0;
        end else begin
            if (bus.clr_err) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_grant <= 2'b00;
                    if (bus.enable && w_any) begin
                        r_grant    <= w_pick1 ? 2'b10 : 2'b01;
                        r_f0_rd_en <= !w_pick1;
                        r_f1_rd_en <= w_pick1;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_f0_rd_en <= 1'b0;
                    r_f1_rd_en <= 1'b0;
                    r_state    <= S_LATCH;
                end
                S_LATCH: begin
                    r_tx_data  <= r_grant[1] ? bus.f1_data : bus.f0_data;
                    r_tx_start <= 1'b1;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_tx_start <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        // Placed after the clear so a coincident timeout wins.
                        r_err      <= 1'b1;
                        r_last_src <= r_grant[1];
                        r_grant    <= 2'b00;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_frames_sent <= r_frames_sent + 16'd1;
                        r_last_src    <= r_grant[1];
                        r_grant       <= 2'b00;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.f0_rd_en    = r_f0_rd_en;
    assign bus.f1_rd_en    = r_f1_rd_en;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant       = r_grant;
    assign bus.frames_sent = r_frames_sent;
    assign bus.err_timeout = r_err;

endmodule
`default_nettype wire
